// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack-style CPU.
//   - default data/address width and instruction width
//   - FSM state encoding
//   - instruction-register field positions
//   - ALU control bundle and the jump-condition helper
package hack_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned IW_DEFAULT = 16;

  typedef enum logic {
    StFetch = 1'b0,
    StExec  = 1'b1
  } state_e;

  // Instruction-register field positions
  localparam int unsigned TYPE_BIT   = 15;  // 0: A-instruction, 1: C-instruction
  localparam int unsigned A_BIT      = 12;  // ALU y operand: 1 selects inM, 0 selects A
  localparam int unsigned COMP_HI    = 11;
  localparam int unsigned COMP_LO    = 6;
  localparam int unsigned DEST_HI    = 5;
  localparam int unsigned DEST_LO    = 3;
  localparam int unsigned DEST_A_BIT = 5;
  localparam int unsigned DEST_D_BIT = 4;
  localparam int unsigned DEST_M_BIT = 3;
  localparam int unsigned JMP_HI     = 2;
  localparam int unsigned JMP_LO     = 0;

  // Field order matches IR[11:6] so a plain cast of the comp field works
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  // jmp = {lt, eq, gt}
  function automatic logic jump_taken(input logic [2:0] jmp, input logic ng, input logic zr);
    return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_alu.sv
// alu: Hack ALU.
//   i_x, i_y : operands (x is D, y is A or inM)
//   i_ctrl   : zx, nx, zy, ny, f, no
//   o_out    : result; o_zr: result is zero; o_ng: result is negative (MSB set)
// Operation order: zero, then invert, then add (mod 2^DW) or AND, then invert.
module alu
  import hack_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_y,
  input  alu_ctrl_t     i_ctrl,
  output logic [DW-1:0] o_out,
  output logic          o_zr,
  output logic          o_ng
);

  logic [DW-1:0] w_x_z;
  logic [DW-1:0] w_x_n;
  logic [DW-1:0] w_y_z;
  logic [DW-1:0] w_y_n;
  logic [DW-1:0] w_f;

  always_comb begin
    w_x_z = i_ctrl.zx ? '0 : i_x;
    w_x_n = i_ctrl.nx ? ~w_x_z : w_x_z;
    w_y_z = i_ctrl.zy ? '0 : i_y;
    w_y_n = i_ctrl.ny ? ~w_y_z : w_y_z;
    w_f   = i_ctrl.f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    o_out = i_ctrl.no ? ~w_f : w_f;
    o_zr  = (o_out == '0);
    o_ng  = o_out[DW-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: two-state (FETCH/EXEC) Hack-style CPU core.
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   instr        : instruction word, accepted in FETCH when instr_valid is high
//   instr_valid  : instruction-present strobe
//   instr_req    : fetch request (high in FETCH)
//   inM          : data-memory read value at addressM
//   outM         : data-memory write value (ALU result)
//   writeM       : data-memory write enable (EXEC of a dest-M C-instruction only)
//   addressM     : data-memory address (register A, pre-update during EXEC)
//   pc           : address of next instruction to fetch
module hack_cpu
  import hack_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_req,
  input  logic [DW-1:0] inM,
  output logic [DW-1:0] outM,
  output logic          writeM,
  output logic [DW-1:0] addressM,
  output logic [DW-1:0] pc
);

  state_e        r_state;
  state_e        w_state_next;
  logic [IW-1:0] r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_pc;

  logic          w_ir_load;
  logic          w_exec;
  logic          w_is_c;
  logic          w_load_a;
  logic          w_load_d;
  logic          w_jump;
  logic [DW-1:0] w_a_next;
  logic [DW-1:0] w_pc_next;
  logic [DW-1:0] w_alu_y;
  logic [DW-1:0] w_alu_out;
  logic          w_alu_zr;
  logic          w_alu_ng;
  alu_ctrl_t     w_alu_ctrl;
  logic          w_unused_ir;

  // FSM next-state and handshake
  always_comb begin
    w_state_next = r_state;
    instr_req    = 1'b0;
    w_ir_load    = 1'b0;
    w_exec       = 1'b0;
    unique case (r_state)
      StFetch: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          w_ir_load    = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_exec       = 1'b1;
        w_state_next = StFetch;
      end
      default: w_state_next = StFetch;
    endcase
  end

  // Decode
  always_comb begin
    w_is_c     = r_ir[TYPE_BIT];
    w_alu_ctrl = alu_ctrl_t'(r_ir[COMP_HI:COMP_LO]);
    w_alu_y    = r_ir[A_BIT] ? inM : r_a;
    w_load_a   = w_exec & (~w_is_c | r_ir[DEST_A_BIT]);
    w_load_d   = w_exec & w_is_c & r_ir[DEST_D_BIT];
    w_a_next   = w_is_c ? w_alu_out : r_ir[DW-1:0];
    w_jump     = w_is_c & jump_taken(r_ir[JMP_HI:JMP_LO], w_alu_ng, w_alu_zr);
    // Jump target is the pre-update A even when A is also a destination
    w_pc_next  = w_jump ? r_a : (r_pc + DW'(1));
  end

  // Bits 14:13 of a C-instruction carry no meaning
  assign w_unused_ir = ^r_ir[14:13];

  alu #(
    .DW(DW)
  ) u_alu (
    .i_x   (r_d),
    .i_y   (w_alu_y),
    .i_ctrl(w_alu_ctrl),
    .o_out (w_alu_out),
    .o_zr  (w_alu_zr),
    .o_ng  (w_alu_ng)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a  <= '0;
      r_d  <= '0;
      r_pc <= '0;
    end else if (w_exec) begin
      if (w_load_a) r_a <= w_a_next;
      if (w_load_d) r_d <= w_alu_out;
      r_pc <= w_pc_next;
    end
  end

  assign outM     = w_alu_out;
  assign addressM = r_a;
  assign pc       = r_pc;
  // State is forced to FETCH asynchronously, so this drops as soon as rst rises
  assign writeM   = w_exec & w_is_c & r_ir[DEST_M_BIT];

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: table-driven, scoreboarded bench for hack_cpu.
module tb_hack_cpu;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_req;
  logic [DW-1:0] inM = '0;
  logic [DW-1:0] outM;
  logic          writeM;
  logic [DW-1:0] addressM;
  logic [DW-1:0] pc;

  hack_cpu #(
    .DW(DW),
    .IW(IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_req  (instr_req),
    .inM        (inM),
    .outM       (outM),
    .writeM     (writeM),
    .addressM   (addressM),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  in_m;
    logic        exp_wm;
    logic [7:0]  exp_addr;
    logic        chk_out;
    logic [7:0]  exp_out;
    logic [7:0]  exp_pc;
  } vec_t;

  typedef struct {
    int          id;
    logic        exp_wm;
    logic [7:0]  exp_addr;
    logic        chk_out;
    logic [7:0]  exp_out;
    logic [7:0]  exp_pc;
  } exp_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];
  exp_t sb_q [$];
  exp_t cur;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: pops expectations in EXEC, checks pc on the following FETCH
  logic       pend_pc = 1'b0;
  logic [7:0] pend_pc_val;
  int         pend_id;

  always @(negedge clk) begin
    if (!rst) begin
      if (!instr_req) begin
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          check($sformatf("v%0d writeM", cur.id), 16'(writeM), 16'(cur.exp_wm));
          check($sformatf("v%0d addressM", cur.id), 16'(addressM), 16'(cur.exp_addr));
          if (cur.chk_out)
            check($sformatf("v%0d outM", cur.id), 16'(outM), 16'(cur.exp_out));
          pend_pc     = 1'b1;
          pend_pc_val = cur.exp_pc;
          pend_id     = cur.id;
        end
      end else if (pend_pc) begin
        check($sformatf("v%0d pc", pend_id), 16'(pc), 16'(pend_pc_val));
        pend_pc = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!instr_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_req) begin
      n_checks++;
      $display("FAIL v%0d fetch timeout: instr_req=%0b, want 1", id, instr_req);
      return;
    end
    check($sformatf("v%0d fetch writeM", id), 16'(writeM), 16'h0);
    e.id       = id;
    e.exp_wm   = v.exp_wm;
    e.exp_addr = v.exp_addr;
    e.chk_out  = v.chk_out;
    e.exp_out  = v.exp_out;
    e.exp_pc   = v.exp_pc;
    sb_q.push_back(e);
    instr       = v.instr;
    inM         = v.in_m;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    vec_t tail;
    //           instr     inM    wm  addr   chk out    pc
    vecs[0]  = '{16'h0005, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01};  // A=5
    vecs[1]  = '{16'hE090, 8'h00, 0, 8'h05, 1, 8'h05, 8'h02};  // D=D+A
    vecs[2]  = '{16'hE300, 8'h00, 0, 8'h05, 1, 8'h05, 8'h03};  // D
    vecs[3]  = '{16'h0010, 8'h00, 0, 8'h05, 0, 8'h00, 8'h04};  // A=0x10
    vecs[4]  = '{16'hEFD0, 8'h00, 0, 8'h10, 1, 8'h01, 8'h05};  // D=1
    vecs[5]  = '{16'hE7D0, 8'h00, 0, 8'h10, 1, 8'h02, 8'h06};  // D=D+1
    vecs[6]  = '{16'hE7D0, 8'h00, 0, 8'h10, 1, 8'h03, 8'h07};  // D=D+1
    vecs[7]  = '{16'hF088, 8'h04, 1, 8'h10, 1, 8'h07, 8'h08};  // M=D+M
    vecs[8]  = '{16'h0020, 8'h00, 0, 8'h10, 0, 8'h00, 8'h09};  // A=0x20
    vecs[9]  = '{16'hEE90, 8'h00, 0, 8'h20, 1, 8'hFF, 8'h0A};  // D=-1
    vecs[10] = '{16'hE304, 8'h00, 0, 8'h20, 1, 8'hFF, 8'h20};  // D;JLT taken
    vecs[11] = '{16'hEFD0, 8'h00, 0, 8'h20, 1, 8'h01, 8'h21};  // D=1
    vecs[12] = '{16'hE304, 8'h00, 0, 8'h20, 1, 8'h01, 8'h22};  // D;JLT not taken
    vecs[13] = '{16'hEA82, 8'h00, 0, 8'h20, 1, 8'h00, 8'h20};  // 0;JEQ taken
    vecs[14] = '{16'h0030, 8'h00, 0, 8'h20, 0, 8'h00, 8'h21};  // A=0x30
    vecs[15] = '{16'hE321, 8'h00, 0, 8'h30, 1, 8'h01, 8'h30};  // A=D;JGT -> old A
    vecs[16] = '{16'hE300, 8'h00, 0, 8'h01, 1, 8'h01, 8'h31};  // A now 1
    vecs[17] = '{16'h00FF, 8'h00, 0, 8'h01, 0, 8'h00, 8'h32};  // A=0xFF
    vecs[18] = '{16'hEA87, 8'h00, 0, 8'hFF, 1, 8'h00, 8'hFF};  // 0;JMP
    vecs[19] = '{16'hE300, 8'h00, 0, 8'hFF, 1, 8'h01, 8'h00};  // pc wraps
    vecs[20] = '{16'h7FAB, 8'h00, 0, 8'hFF, 0, 8'h00, 8'h01};  // A=low byte
    vecs[21] = '{16'hEC10, 8'h00, 0, 8'hAB, 1, 8'hAB, 8'h02};  // D=A
    vecs[22] = '{16'hF000, 8'h0F, 0, 8'hAB, 1, 8'h0B, 8'h03};  // D&M

    // Reset behaviour
    repeat (2) @(negedge clk);
    check("rst writeM", 16'(writeM), 16'h0);
    check("rst pc", 16'(pc), 16'h0);
    check("rst addressM", 16'(addressM), 16'h0);
    rst = 1'b0;
    #1;
    check("post-rst instr_req", 16'(instr_req), 16'h1);
    check("post-rst pc", 16'(pc), 16'h0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Idle FETCH: nothing moves without instr_valid
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle%0d instr_req", i), 16'(instr_req), 16'h1);
      check($sformatf("idle%0d pc", i), 16'(pc), 16'h03);
      check($sformatf("idle%0d writeM", i), 16'(writeM), 16'h0);
      @(negedge clk);
    end

    // Reset in the middle of a dest-M EXEC (A=0xAB, D=0xAB)
    instr       = 16'hF088;
    inM         = 8'h10;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("abort exec writeM", 16'(writeM), 16'h1);
    check("abort exec outM", 16'(outM), 16'h00BB);
    #2 rst = 1'b1;
    #1;
    check("abort writeM", 16'(writeM), 16'h0);
    check("abort pc", 16'(pc), 16'h0);
    check("abort addressM", 16'(addressM), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort release instr_req", 16'(instr_req), 16'h1);
    check("abort release pc", 16'(pc), 16'h0);
    // D must have been cleared: comp D shows 0, fetched from pc 0
    tail = '{16'hE300, 8'h00, 0, 8'h00, 1, 8'h00, 8'h01};
    run_vec(tail, NVEC);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 16'(sb_q.size()), 16'h0);
    check("pc check drained", 16'(pend_pc), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data/address/PC width.
REQ-002 SHALL have parameter IW, default 16, meaning instruction width.
REQ-003 SHALL have ports clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports instr  in  IW  instruction word, valid with instr_valid.
REQ-006 SHALL have ports instr_valid  in  1  instruction-present strobe.
REQ-007 SHALL have ports instr_req  out  1  fetch request.
REQ-008 SHALL have ports inM  in  DW  data-memory read value at addressM.
REQ-009 SHALL have ports outM  out  DW  data-memory write value (ALU result).
REQ-010 SHALL have ports writeM  out  1  data-memory write enable.
REQ-011 SHALL have ports addressM  out  DW  data-memory address (register A).
REQ-012 SHALL have ports pc  out  DW  address of next instruction to fetch.

Function
REQ-013 SHALL run a two-state FSM: FETCH, EXEC.
REQ-014 In FETCH, instr_req=1; on instr_valid=1, SHALL latch instr into IR and enter EXEC next cycle; otherwise SHALL stay in FETCH.
REQ-015 In EXEC, SHALL hold instr_req=0, spend exactly one cycle and return to FETCH.
REQ-016 IR[15]=0 (A-instr): SHALL load A <= IR[DW-1:0] at end of EXEC; writeM=0; D unchanged.
REQ-017 IR[15]=1 (C-instr): ALU x=D; y=inM if IR[12]=1, else A; zx,nx,zy,ny,f,no = IR[11:6]; ALU semantics: zero, then invert, then add (mod 2^DW) or AND, then invert.
REQ-018 C-instr dest IR[5:3] (A,D,M): A and/or D SHALL load the ALU result at end of EXEC; writeM=IR[3] combinationally during EXEC only.
REQ-019 outM SHALL equal the ALU result; addressM SHALL equal current A (pre-update) throughout EXEC.
REQ-020 Jump bits IR[2:0] (lt,eq,gt): take jump when (IR[2]&ng)|(IR[1]&zr)|(IR[0]&~ng&~zr).
REQ-021 At end of EXEC, pc SHALL load the pre-update A if jump taken, else pc+1 mod 2^DW (255 -> 0).
REQ-022 dest A and jump taken together: jump target SHALL be the old A; A then takes the ALU result.
REQ-023 writeM SHALL be 0 in FETCH and throughout reset.
REQ-024 A, D, pc, IR SHALL change only at end of EXEC (IR: end of accepted FETCH).

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH, A=0, D=0, pc=0, IR=0, writeM=0, instr_req=1 once rst deasserts.
REQ-026 Reset mid-EXEC SHALL abort the instruction: no register or memory write.
REQ-027 First fetch after reset release SHALL be from pc=0.

Structure
REQ-028 Shared package hack_pkg SHALL hold: DW/IW defaults, FSM state encoding, IR field positions (a-bit 12, comp 11:6, dest 5:3, jump 2:0, type 15).
REQ-029 SHALL instantiate exactly one sub-module, alu, for all computation; no duplicate arithmetic in hack_cpu.
REQ-030 FSM, IR, A, D, pc SHALL be flops on clk/rst; decode and jump logic combinational.

Verification
REQ-031 Reset, then instr=0x0005 valid -> after EXEC, A=5, D=0, pc=1, writeM never 1.
REQ-032 A=5, D=0; instr 0xEC10 (D=A) then 0xE7D0? no: use comp x+y, dest D, a=0 -> D=5, pc increments, writeM=0.
REQ-033 A=0x10, D=3, inM=4; comp D+M, dest M (0xF088) -> during EXEC writeM=1, addressM=0x10, outM=7; next FETCH writeM=0.
REQ-034 A=0x20, D=0xFF; comp D, jump JLT -> ng=1, pc=0x20; same with D=1 -> pc=old pc+1.
REQ-035 pc=0xFF, non-jumping instr -> pc wraps to 0x00; instr_valid held low 3 cycles in FETCH -> state and pc unchanged.
REQ-036 rst asserted during EXEC of a dest-M instr -> writeM=0 immediately, A=D=pc=0, state FETCH.
